fwd_hazard_unit: RTL and testbench

- Parametrised forwarding, interlock and memory-bypass unit for the rv32i pipeline. It generalises the fixed two-stage, two-operand hazard logic to NUM_SRC operands and NUM_STG downstream stages.
- Adds a load-use interlock FSM with performance counters.
- Adds a small store-bypass buffer that serves loads hitting recently written words without a data-memory read.
- Sits between the ID/EX register, the downstream pipeline registers and the data-memory port.

---
 rtl/fwd_hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding with youngest-stage priority, load-use interlock with counters,
// and a small store-bypass buffer that answers loads fully covered by recent stores.
module fwd_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_STG  = 2,
  parameter int SB_DEPTH = 4,
  parameter int SELW     = $clog2(NUM_STG + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*5-1:0]      ex_rs,
  input  logic [NUM_SRC-1:0]        ex_rs_used,
  input  logic [NUM_STG*5-1:0]      stg_rd,
  input  logic [NUM_STG-1:0]        stg_wr,
  input  logic [NUM_STG-1:0]        stg_dvalid,
  input  logic [NUM_STG*XLEN-1:0]   stg_data,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic                      stall_ex,
  input  logic                      dmem_read_in,
  input  logic                      dmem_write_in,
  input  logic [XLEN-1:0]           dmem_addr,
  input  logic [3:0]                dmem_mbe,
  input  logic [XLEN-1:0]           dmem_wdata,
  input  logic                      dmem_resp,
  output logic                      dmem_read,
  output logic                      sb_hit,
  output logic [XLEN-1:0]           sb_rdata,
  input  logic                      sb_flush,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               interlock_events
);

  localparam int AW = XLEN - 2;
  localparam int PW = $clog2(SB_DEPTH);

  typedef enum logic [0:0] {RUN, INTERLOCK} state_t;

  logic [NUM_SRC-1:0] op_pending;
  logic               raw_stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [4:0]      rs;
      logic [SELW-1:0] sel;
      logic [XLEN-1:0] data;
      logic            pend;

      assign rs = ex_rs[gi*5 +: 5];

      // Scan oldest to youngest so the youngest matching stage is the last write.
      always_comb begin
        sel  = '0;
        data = '0;
        pend = 1'b0;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
          if (ex_rs_used[gi] && stg_wr[k] && (rs != 5'd0) && (stg_rd[k*5 +: 5] == rs)) begin
            sel  = SELW'(k + 1);
            data = stg_data[k*XLEN +: XLEN];
            pend = !stg_dvalid[k];
          end
        end
      end

      assign fwd_sel[gi*SELW +: SELW]  = sel;
      assign fwd_data[gi*XLEN +: XLEN] = data;
      assign op_pending[gi]            = pend;
    end
  endgenerate

  assign raw_stall = ex_valid && (|op_pending);
  assign stall_ex  = raw_stall;

  state_t      state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] event_cnt_q, event_cnt_d;

  always_comb begin
    state_d     = raw_stall ? INTERLOCK : RUN;
    stall_cnt_d = stall_cnt_q;
    event_cnt_d = event_cnt_q;
    if (raw_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (raw_stall && (state_q == RUN) && (event_cnt_q != '1))
      event_cnt_d = event_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign stall_cycles     = stall_cnt_q;
  assign interlock_events = event_cnt_q;

  logic [SB_DEPTH-1:0] sb_valid_q;
  logic [AW-1:0]       sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]     sb_data_q [SB_DEPTH];
  logic [3:0]          sb_mbe_q  [SB_DEPTH];
  logic [PW-1:0]       wr_ptr_q;

  logic [AW-1:0]   word_addr;
  logic [XLEN-1:0] byte_mask;
  logic            match_any;
  logic [PW-1:0]   match_idx;
  logic            lookup;
  logic            capture;
  logic            unused_addr_bits;

  assign word_addr        = dmem_addr[XLEN-1:2];
  assign unused_addr_bits = ^dmem_addr[1:0];

  // At most one entry per word address, so the first match is the only one.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int e = SB_DEPTH - 1; e >= 0; e--) begin
      if (sb_valid_q[e] && (sb_addr_q[e] == word_addr)) begin
        match_any = 1'b1;
        match_idx = PW'(e);
      end
    end
  end

  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++)
      byte_mask[b*8 +: 8] = {8{dmem_mbe[b]}};
  end

  assign lookup    = dmem_read_in && !dmem_write_in;
  assign sb_hit    = lookup && match_any && ((sb_mbe_q[match_idx] & dmem_mbe) == dmem_mbe);
  assign sb_rdata  = sb_hit ? (sb_data_q[match_idx] & byte_mask) : '0;
  assign dmem_read = dmem_read_in && !sb_hit;
  assign capture   = dmem_write_in && dmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_valid_q <= '0;
      wr_ptr_q   <= '0;
      for (int e = 0; e < SB_DEPTH; e++) begin
        sb_addr_q[e] <= '0;
        sb_data_q[e] <= '0;
        sb_mbe_q[e]  <= '0;
      end
    end else if (sb_flush) begin
      sb_valid_q <= '0;
      wr_ptr_q   <= '0;
    end else if (capture) begin
      if (match_any) begin
        sb_data_q[match_idx] <= (sb_data_q[match_idx] & ~byte_mask) | (dmem_wdata & byte_mask);
        sb_mbe_q[match_idx]  <= sb_mbe_q[match_idx] | dmem_mbe;
      end else begin
        sb_valid_q[wr_ptr_q] <= 1'b1;
        sb_addr_q[wr_ptr_q]  <= word_addr;
        sb_data_q[wr_ptr_q]  <= dmem_wdata & byte_mask;
        sb_mbe_q[wr_ptr_q]   <= dmem_mbe;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use interlock,
// counters, store-bypass hit/miss/merge/wrap/flush and reset mid-interlock.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [9:0]  ex_rs;
  logic [1:0]  ex_rs_used;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_wr;
  logic [1:0]  stg_dvalid;
  logic [63:0] stg_data;
  logic [3:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic        stall_ex;
  logic        dmem_read_in, dmem_write_in, dmem_resp, sb_flush;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_read, sb_hit;
  logic [31:0] sb_rdata, stall_cycles, interlock_events;

  int n_checks = 0;
  int n_pass   = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rs_used(ex_rs_used),
    .stg_rd(stg_rd), .stg_wr(stg_wr), .stg_dvalid(stg_dvalid), .stg_data(stg_data),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall_ex(stall_ex),
    .dmem_read_in(dmem_read_in), .dmem_write_in(dmem_write_in), .dmem_addr(dmem_addr),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
    .dmem_read(dmem_read), .sb_hit(sb_hit), .sb_rdata(sb_rdata), .sb_flush(sb_flush),
    .stall_cycles(stall_cycles), .interlock_events(interlock_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_rs = '0; ex_rs_used = '0;
    stg_rd = '0; stg_wr = '0; stg_dvalid = '0; stg_data = '0;
    dmem_read_in = 0; dmem_write_in = 0; dmem_resp = 0; sb_flush = 0;
    dmem_addr = '0; dmem_wdata = '0; dmem_mbe = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic resp, input logic flush);
    dmem_write_in = 1; dmem_resp = resp; sb_flush = flush;
    dmem_addr = a; dmem_wdata = d; dmem_mbe = m;
    tick();
    dmem_write_in = 0; dmem_resp = 0; sb_flush = 0;
    $display("store addr=%h data=%h mbe=%b resp=%b flush=%b", a, d, m, resp, flush);
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic exp_hit, input logic [31:0] exp_data);
    dmem_read_in = 1; dmem_addr = a; dmem_mbe = m;
    #1;
    $display("load  addr=%h mbe=%b hit=%b rdata=%h", a, m, sb_hit, sb_rdata);
    chk({tag, ".hit"}, {31'd0, sb_hit}, {31'd0, exp_hit});
    chk({tag, ".rd"}, {31'd0, dmem_read}, {31'd0, !exp_hit});
    chk({tag, ".data"}, sb_rdata, exp_data);
    tick();
    dmem_read_in = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst.sel", {28'd0, fwd_sel}, 32'd0);
    chk("rst.data", fwd_data[31:0] | fwd_data[63:32], 32'd0);
    chk("rst.stall", {31'd0, stall_ex}, 32'd0);
    chk("rst.misc", {29'd0, dmem_read, sb_hit, |sb_rdata}, 32'd0);
    chk("rst.cyc", stall_cycles, 32'd0);
    chk("rst.evt", interlock_events, 32'd0);

    // No hazard
    ex_valid = 1; ex_rs_used = 2'b11; ex_rs = {5'd4, 5'd3};
    stg_rd = {5'd2, 5'd1}; stg_wr = 2'b11; stg_dvalid = 2'b11;
    stg_data = {32'h0000BBBB, 32'h0000AAAA};
    #1;
    chk("nohaz.sel", {28'd0, fwd_sel}, 32'd0);
    chk("nohaz.stall", {31'd0, stall_ex}, 32'd0);
    chk("nohaz.data", fwd_data[31:0], 32'd0);

    // Both stages write r5: youngest wins for both operands
    stg_rd = {5'd5, 5'd5}; ex_rs = {5'd5, 5'd5};
    #1;
    chk("dbl.sel", {28'd0, fwd_sel}, 32'h5);
    chk("dbl.data0", fwd_data[31:0], 32'h0000AAAA);
    chk("dbl.data1", fwd_data[63:32], 32'h0000AAAA);
    ex_rs = {5'd5, 5'd0};
    stg_rd = {5'd0, 5'd0}; stg_wr = 2'b00;
    #1;
    chk("x0.sel", {28'd0, fwd_sel}, 32'h0);
    stg_rd = {5'd5, 5'd5}; stg_wr = 2'b11;
    #1;
    chk("x0b.sel", {28'd0, fwd_sel}, 32'h4);
    chk("x0b.data0", fwd_data[31:0], 32'd0);

    // Operands pick different stages
    stg_rd = {5'd5, 5'd6}; ex_rs = {5'd6, 5'd5};
    #1;
    chk("indep.sel", {28'd0, fwd_sel}, 32'h6);
    chk("indep.data0", fwd_data[31:0], 32'h0000BBBB);
    chk("indep.data1", fwd_data[63:32], 32'h0000AAAA);
    ex_rs_used = 2'b01;
    #1;
    chk("unused.sel", {28'd0, fwd_sel}, 32'h2);
    tick();

    // Load-use: stage 0 pending for three cycles
    ex_rs_used = 2'b11; ex_rs = {5'd7, 5'd3};
    stg_rd = {5'd0, 5'd7}; stg_wr = 2'b01; stg_dvalid = 2'b00; stg_data = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("interlock cycle %0d stall=%b sel=%h", c, stall_ex, fwd_sel);
      chk("lu.stall", {31'd0, stall_ex}, 32'd1);
      chk("lu.sel", {28'd0, fwd_sel}, 32'h4);
      tick();
    end
    stg_dvalid = 2'b01; stg_data = {32'd0, 32'h00001234};
    #1;
    chk("lu.release", {31'd0, stall_ex}, 32'd0);
    chk("lu.data", fwd_data[63:32], 32'h00001234);
    chk("lu.cyc", stall_cycles, 32'd3);
    chk("lu.evt", interlock_events, 32'd1);
    tick();
    chk("lu.cyc2", stall_cycles, 32'd3);
    stg_dvalid = 2'b00;
    tick();
    stg_dvalid = 2'b01;
    #1;
    chk("lu2.cyc", stall_cycles, 32'd4);
    chk("lu2.evt", interlock_events, 32'd2);
    ex_valid = 0; stg_dvalid = 2'b00;
    #1;
    chk("lu.novalid", {31'd0, stall_ex}, 32'd0);
    idle();
    tick();

    // Store buffer hit and miss
    store(32'h100, 32'hDEADBEEF, 4'b1111, 1, 0);
    load("hit100", 32'h100, 4'b0100, 1, 32'h00AD0000);
    load("miss104", 32'h104, 4'b1111, 0, 32'd0);

    // Byte merge into one entry
    store(32'h200, 32'h00000011, 4'b0001, 1, 0);
    store(32'h200, 32'h00002200, 4'b0010, 1, 0);
    load("merge", 32'h200, 4'b0011, 1, 32'h00002211);
    load("partial", 32'h200, 4'b0111, 0, 32'd0);

    // No capture without response
    store(32'h600, 32'h66666666, 4'b1111, 0, 0);
    load("noresp", 32'h600, 4'b1111, 0, 32'd0);

    // Fill and wrap: 0x500 replaces the oldest (0x100)
    store(32'h300, 32'h33333333, 4'b1111, 1, 0);
    store(32'h400, 32'h44444444, 4'b1111, 1, 0);
    store(32'h500, 32'h55555555, 4'b1111, 1, 0);
    load("evicted", 32'h100, 4'b0100, 0, 32'd0);
    load("kept200", 32'h202, 4'b0011, 1, 32'h00002211);
    load("new500", 32'h500, 4'b1111, 1, 32'h55555555);

    // Read and write together is not a lookup
    dmem_read_in = 1; dmem_write_in = 1; dmem_addr = 32'h500; dmem_mbe = 4'b1111;
    #1;
    chk("rdwr.hit", {31'd0, sb_hit}, 32'd0);
    chk("rdwr.rd", {31'd0, dmem_read}, 32'd1);
    idle();
    tick();

    // Flush coinciding with a capture: flush wins
    store(32'h700, 32'h77777777, 4'b1111, 1, 1);
    load("fl700", 32'h700, 4'b1111, 0, 32'd0);
    load("fl500", 32'h500, 4'b1111, 0, 32'd0);
    load("fl300", 32'h300, 4'b1111, 0, 32'd0);

    // Reset in the middle of an interlock
    ex_valid = 1; ex_rs_used = 2'b01; ex_rs = {5'd0, 5'd9};
    stg_rd = {5'd0, 5'd9}; stg_wr = 2'b01; stg_dvalid = 2'b00;
    tick(); tick();
    rst = 1;
    #1;
    chk("rsti.stall", {31'd0, stall_ex}, 32'd1);
    tick();
    chk("rsti.cyc", stall_cycles, 32'd0);
    chk("rsti.evt", interlock_events, 32'd0);
    rst = 0;
    tick();
    chk("rsti.run_evt", interlock_events, 32'd1);
    chk("rsti.run_cyc", stall_cycles, 32'd1);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
